// File: rtl/expansion_bus_slave.sv
// C64 expansion-port slave: syncs the port, one read/write strobe per selected cycle; read strobe SETTLE_CYCLES+1 clk after synced phi2 rise, oe 2 clk later.
// No backpressure (register file must accept every strobe); optional BUS_TIMEOUT_EN closes cycles held open past TIMEOUT_CYCLES.
module expansion_bus_slave #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_phi2,
    input  logic       bus_rw,
    input  logic       bus_io1_n,
    input  logic       bus_io2_n,
    input  logic [7:0] bus_a,
    input  logic [7:0] bus_d_in,
    output logic [7:0] bus_d_out,
    output logic       bus_d_oe,
    output logic [8:0] a,
    output logic [7:0] d_d,
    input  logic [7:0] d_q,
    output logic       read_strobe,
    output logic       write_strobe
);
    typedef enum logic [2:0] {IDLE, SETTLE, RD_REQ, RD_CAP, DRIVE, WR_ACC, WAIT_LOW} state_t;

    localparam int SW  = 20;
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);

    // Control, address and data share one pipeline so they stay aligned.
    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SW-1:0] sync_d [SYNC_STAGES];

    always_comb begin
        sync_d[0] = {bus_phi2, bus_rw, ~bus_io1_n, ~bus_io2_n, bus_a, bus_d_in};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
        end
    end

    logic       phi2_s, rw_s, sel1_s, sel2_s, sel_s;
    logic [7:0] a_s, din_s;
    assign {phi2_s, rw_s, sel1_s, sel2_s, a_s, din_s} = sync_q[SYNC_STAGES-1];
    assign sel_s = sel1_s | sel2_s;

    state_t         state_q, state_d;
    logic           phi2_prev_q, phi2_prev_d;
    logic [8:0]     a_q, a_d;
    logic [7:0]     wdat_q, wdat_d;
    logic [7:0]     dout_q, dout_d;
    logic           oe_q, oe_d;
    logic [SCW-1:0] settle_cnt_q, settle_cnt_d;
    logic           rise, end_ev, active, tmo_hit;

    assign phi2_prev_d = phi2_s;
    assign rise        = phi2_s & ~phi2_prev_q;
    assign end_ev      = ~phi2_s | ~sel_s;
    assign active      = (state_q == SETTLE) || (state_q == RD_REQ) || (state_q == RD_CAP) ||
                         (state_q == DRIVE)  || (state_q == WR_ACC);

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_cnt_d = active ? tmo_cnt_q + TW'(1) : '0;
    assign tmo_hit   = active && (tmo_cnt_q >= TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`else
    // Without the timeout option a cycle stays open until it ends on the bus.
    assign tmo_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (rise && sel_s) state_d = rw_s ? SETTLE : WR_ACC;
            SETTLE:   if (tmo_hit)      state_d = WAIT_LOW;
                      else if (end_ev)  state_d = IDLE;
                      else if (settle_cnt_q >= SCW'(SETTLE_CYCLES - 1)) state_d = RD_REQ;
            RD_REQ:   state_d = tmo_hit ? WAIT_LOW : RD_CAP;
            RD_CAP:   state_d = tmo_hit ? WAIT_LOW : DRIVE;
            DRIVE:    if (tmo_hit || end_ev) state_d = WAIT_LOW;
            WR_ACC:   if (tmo_hit || end_ev) state_d = WAIT_LOW;
            WAIT_LOW: if (!phi2_s) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        read_strobe  = (state_q == RD_REQ) && !tmo_hit;
        write_strobe = (state_q == WR_ACC) && end_ev && !tmo_hit;
        a_d          = a_q;
        wdat_d       = wdat_q;
        dout_d       = dout_q;
        oe_d         = oe_q;
        settle_cnt_d = settle_cnt_q;
        unique case (state_q)
            IDLE: if (rise && sel_s) begin
                a_d          = {sel2_s, a_s};
                settle_cnt_d = '0;
            end
            SETTLE: if (!end_ev) begin
                a_d = {sel2_s, a_s};
                if (settle_cnt_q != SCW'(SETTLE_CYCLES)) settle_cnt_d = settle_cnt_q + SCW'(1);
            end
            RD_CAP: if (!tmo_hit) begin
                dout_d = d_q;
                oe_d   = 1'b1;
            end
            DRIVE:  if (end_ev) oe_d = 1'b0;
            // Only data seen while the cycle is still valid is kept.
            WR_ACC: if (phi2_s && sel_s) wdat_d = din_s;
            default: ;
        endcase
        if (tmo_hit) oe_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phi2_prev_q  <= 1'b0;
            a_q          <= '0;
            wdat_q       <= '0;
            dout_q       <= '0;
            oe_q         <= 1'b0;
            settle_cnt_q <= '0;
        end else begin
            phi2_prev_q  <= phi2_prev_d;
            a_q          <= a_d;
            wdat_q       <= wdat_d;
            dout_q       <= dout_d;
            oe_q         <= oe_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign a         = a_q;
    assign d_d       = wdat_q;
    assign bus_d_out = dout_q;
    assign bus_d_oe  = oe_q;
endmodule

// File: tb/tb_expansion_bus_slave.sv
// Directed bench for expansion_bus_slave: table of bus cycles plus hand sequences for abort, reset and long cycles.
module tb_expansion_bus_slave;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bus_phi2 = 1'b0, bus_rw = 1'b1, bus_io1_n = 1'b1, bus_io2_n = 1'b1;
    logic [7:0] bus_a = '0, bus_d_in = '0, d_q = 8'hEE, rf_val = '0;
    logic [7:0] bus_d_out, d_d;
    logic [8:0] a;
    logic       bus_d_oe, read_strobe, write_strobe;

    expansion_bus_slave dut (
        .clk(clk), .rst(rst), .bus_phi2(bus_phi2), .bus_rw(bus_rw),
        .bus_io1_n(bus_io1_n), .bus_io2_n(bus_io2_n), .bus_a(bus_a), .bus_d_in(bus_d_in),
        .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .a(a), .d_d(d_d), .d_q(d_q),
        .read_strobe(read_strobe), .write_strobe(write_strobe)
    );

    always #5 clk = ~clk;

    // Register-file model: data valid only in the clk after read_strobe.
    always @(posedge clk) d_q <= read_strobe ? rf_val : 8'hEE;

    int         cyc = 0;
    int         rd_cnt = 0, wr_cnt = 0, both_cnt = 0, oe_cnt = 0;
    int         rd_cyc = 0, oe_rise_cyc = 0, oe_fall_cyc = 0;
    logic       oe_prev = 1'b0;
    logic [8:0] last_rd_a = '0, last_wr_a = '0;
    logic [7:0] last_wr_d = '0, last_dout = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (read_strobe)  begin rd_cnt++; rd_cyc = cyc; last_rd_a = a; end
        if (write_strobe) begin wr_cnt++; last_wr_a = a; last_wr_d = d_d; end
        if (read_strobe && write_strobe) both_cnt++;
        if (bus_d_oe) begin oe_cnt++; last_dout = bus_d_out; end
        if (bus_d_oe && !oe_prev) oe_rise_cyc = cyc;
        if (!bus_d_oe && oe_prev) oe_fall_cyc = cyc;
        oe_prev = bus_d_oe;
    end

    int n_chk = 0, n_bad = 0;
    int t_rise = 0, t_fall = 0, rd0 = 0, wr0 = 0, oe0 = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic snap();
        rd0 = rd_cnt; wr0 = wr_cnt; oe0 = oe_cnt;
    endtask

    task automatic bus_cycle(input logic rw, input logic io1n, input logic io2n,
                             input logic [7:0] ad, input logic [7:0] dat, input logic [7:0] dat_late,
                             input int hi);
        bus_a = ad; bus_d_in = dat; bus_rw = rw; bus_io1_n = io1n; bus_io2_n = io2n;
        wclk(2);
        bus_phi2 = 1'b1; t_rise = cyc;
        wclk(hi - 5);
        bus_d_in = dat_late;
        wclk(5);
        bus_phi2 = 1'b0; t_fall = cyc;
        wclk(1);
        bus_io1_n = 1'b1; bus_io2_n = 1'b1; bus_rw = 1'b1;
        wclk(8);
    endtask

    typedef struct {
        logic       rw, io1n, io2n;
        logic [7:0] ad, dat, dat_late, rf;
        int         exp_rd, exp_wr;
        logic [8:0] exp_a;
        logic [7:0] exp_dd;
    } vec_t;

    vec_t vt [7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //        rw    io1n  io2n  A      D      D late rdata  rd wr a        d_d
        vt[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h3C, 1, 0, 9'h100, 8'h00};
        vt[1] = '{1'b0, 1'b0, 1'b1, 8'h02, 8'h5A, 8'h5A, 8'h00, 0, 1, 9'h002, 8'h5A};
        vt[2] = '{1'b0, 1'b0, 1'b1, 8'h02, 8'h11, 8'hC3, 8'h00, 0, 1, 9'h002, 8'hC3};
        vt[3] = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hA5, 1, 0, 9'h0FF, 8'h00};
        vt[4] = '{1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 8'h01, 1, 0, 9'h180, 8'h00};
        vt[5] = '{1'b0, 1'b1, 1'b0, 8'h7F, 8'hFF, 8'hFF, 8'h00, 0, 1, 9'h17F, 8'hFF};
        vt[6] = '{1'b1, 1'b1, 1'b1, 8'h44, 8'h00, 8'h00, 8'h99, 0, 0, 9'h000, 8'h00};

        wclk(3);
        chk("rst_oe", bus_d_oe, 0);
        chk("rst_dout", bus_d_out, 0);
        chk("rst_a", a, 0);
        chk("rst_dd", d_d, 0);
        chk("rst_rd", read_strobe, 0);
        chk("rst_wr", write_strobe, 0);
        rst = 1'b0;
        wclk(3);

        for (int i = 0; i < 7; i++) begin
            rf_val = vt[i].rf;
            snap();
            bus_cycle(vt[i].rw, vt[i].io1n, vt[i].io2n, vt[i].ad, vt[i].dat, vt[i].dat_late, 20);
            chk($sformatf("v%0d_rd_cnt", i), rd_cnt - rd0, vt[i].exp_rd);
            chk($sformatf("v%0d_wr_cnt", i), wr_cnt - wr0, vt[i].exp_wr);
            if (vt[i].exp_rd != 0) begin
                chk($sformatf("v%0d_rd_a", i), last_rd_a, vt[i].exp_a);
                chk($sformatf("v%0d_dout", i), last_dout, vt[i].rf);
                chk($sformatf("v%0d_rise_to_strobe", i), rd_cyc - t_rise, 5);
                chk($sformatf("v%0d_strobe_to_oe", i), oe_rise_cyc - rd_cyc, 2);
                chk($sformatf("v%0d_oe_fall_ok", i), int'((oe_fall_cyc - t_fall) <= 3), 1);
            end else begin
                chk($sformatf("v%0d_no_oe", i), oe_cnt - oe0, 0);
            end
            if (vt[i].exp_wr != 0) begin
                chk($sformatf("v%0d_wr_a", i), last_wr_a, vt[i].exp_a);
                chk($sformatf("v%0d_wr_dd", i), last_wr_d, vt[i].exp_dd);
            end
            chk($sformatf("v%0d_oe_end", i), bus_d_oe, 0);
        end

        snap();
        for (int i = 0; i < 10; i++)
            bus_cycle(1'(i % 2), 1'b1, 1'b1, 8'(i), 8'h5A, 8'h5A, 20);
        chk("unsel_rd", rd_cnt - rd0, 0);
        chk("unsel_wr", wr_cnt - wr0, 0);
        chk("unsel_oe", oe_cnt - oe0, 0);

        // Select released while the read is still settling.
        snap();
        bus_rw = 1'b1; bus_a = 8'h20; bus_io2_n = 1'b0;
        wclk(2); bus_phi2 = 1'b1;
        wclk(1); bus_io2_n = 1'b1;
        wclk(15); bus_phi2 = 1'b0;
        wclk(8);
        chk("settle_abort_rd", rd_cnt - rd0, 0);
        chk("settle_abort_oe", oe_cnt - oe0, 0);

        // Write whose select drops with new data: strobe keeps the last valid byte.
        snap();
        bus_rw = 1'b0; bus_a = 8'h33; bus_d_in = 8'h77; bus_io1_n = 1'b0;
        wclk(2); bus_phi2 = 1'b1;
        wclk(10); bus_d_in = 8'h99; bus_io1_n = 1'b1;
        wclk(6); bus_phi2 = 1'b0;
        wclk(8); bus_rw = 1'b1;
        chk("wabort_wr", wr_cnt - wr0, 1);
        chk("wabort_a", last_wr_a, 9'h033);
        chk("wabort_dd", last_wr_d, 8'h77);

        // Reset in the middle of a driven read.
        rf_val = 8'h6E;
        bus_rw = 1'b1; bus_a = 8'h10; bus_io2_n = 1'b0;
        wclk(2); bus_phi2 = 1'b1;
        wclk(10);
        chk("pre_rst_oe", bus_d_oe, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_oe", bus_d_oe, 0);
        chk("arst_dout", bus_d_out, 0);
        chk("arst_a", a, 0);
        chk("arst_dd", d_d, 0);
        chk("arst_rd", read_strobe, 0);
        wclk(2);
        rst = 1'b0; bus_phi2 = 1'b0; bus_io2_n = 1'b1;
        wclk(5);
        rf_val = 8'hB7;
        snap();
        bus_cycle(1'b1, 1'b0, 1'b1, 8'h12, 8'h00, 8'h00, 20);
        chk("post_rst_rd", rd_cnt - rd0, 1);
        chk("post_rst_a", last_rd_a, 9'h012);
        chk("post_rst_dout", last_dout, 8'hB7);

        // Cycles held open for 100 clk.
        rf_val = 8'h55;
        snap();
        bus_rw = 1'b1; bus_a = 8'h44; bus_io2_n = 1'b0;
        wclk(2); bus_phi2 = 1'b1; t_rise = cyc;
        wclk(100);
`ifdef BUS_TIMEOUT_EN
        chk("tmo_rd_oe", bus_d_oe, 0);
        chk("tmo_rd_fall", oe_fall_cyc - t_rise, 67);
`else
        chk("long_rd_oe", bus_d_oe, 1);
`endif
        bus_phi2 = 1'b0; wclk(1); bus_io2_n = 1'b1; wclk(8);
        chk("long_rd_cnt", rd_cnt - rd0, 1);

        snap();
        bus_rw = 1'b0; bus_a = 8'h45; bus_d_in = 8'h3D; bus_io2_n = 1'b0;
        wclk(2); bus_phi2 = 1'b1;
        wclk(100);
        bus_phi2 = 1'b0; wclk(1); bus_io2_n = 1'b1; bus_rw = 1'b1; wclk(8);
`ifdef BUS_TIMEOUT_EN
        chk("tmo_wr_cnt", wr_cnt - wr0, 0);
`else
        chk("long_wr_cnt", wr_cnt - wr0, 1);
        chk("long_wr_dd", last_wr_d, 8'h3D);
`endif

        chk("never_both", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
